ysyx_23060278_ifu: RTL and testbench
====================================

// Module: ysyx_23060278_ifu
// PURPOSE
//  Instruction fetch unit: accepts the next PC from the PC register, reads one 32-bit word from
//  instruction memory over an AXI4-Lite-style AR/R read channel, and presents it to the decoder.
//  Uses a valid/ready handshake on both sides.
//  Sits between pc_reg and the decoder/IDU; replaces the direct inst input of the core top.
// PARAMETERS
//  ADDR_W       32             address width (araddr_o, pc_i)
//  TIMEOUT_CYC  16             max cycles spent in AR or R before a timeout fault (>=1)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  pc_i           in   ADDR_W  fetch address from pc_reg
//  pc_valid_i     in   1       pc_i is valid
//  pc_ready_o     out  1       IFU accepts a new PC (high only in IDLE)
//  araddr_o       out  ADDR_W  read address
//  arvalid_o      out  1       read address valid
//  arready_i      in   1       memory accepts the address
//  rdata_i        in   32      read data
//  rresp_i        in   2       read response; 2'b00 = OKAY, anything else = error
//  rvalid_i       in   1       read data valid
//  rready_o       out  1       IFU accepts the read data
//  inst_o         out  32      fetched instruction
//  inst_pc_o      out  ADDR_W  PC of inst_o
//  inst_valid_o   out  1       inst_o/inst_pc_o/fault valid
//  inst_ready_i   in   1       decoder consumes the instruction
//  fault_o        out  1       fetch fault accompanies inst_valid_o
//  fault_cause_o  out  2       00 none, 01 bus error, 10 timeout, 11 misaligned
// BEHAVIOUR
//  - FSM states: IDLE, AR, R, OUT. Registered state; outputs decoded from state.
//  - IDLE: pc_ready_o=1. On pc_valid_i, latch pc_i into pc_q and go to AR.
//  - AR: arvalid_o=1, araddr_o=pc_q.
//    - On arready_i, go to R.
//    - araddr_o must stay stable while arvalid_o=1 and arready_i=0.
//  - R: rready_o=1. On rvalid_i:
//    - Latch inst_q and go to OUT.
//    - rresp_i==00: inst_q=rdata_i, fault=0.
//    - Otherwise: inst_q=32'h0000_0013 (NOP), fault=1, cause=01.
//  - OUT: inst_valid_o=1; inst_o, inst_pc_o and fault held stable. On inst_ready_i, go to IDLE.
//    inst_valid_o never drops before inst_ready_i.
//  - Latency: zero-wait memory gives pc accept at cycle 0, then arvalid in cycle 1,
//    rready in cycle 2, inst_valid in cycle 3. No back-to-back overlap: one fetch in flight.
//  - Timeout: a counter clears on entry to AR and on entry to R, and increments each cycle in AR/R.
//    - If it reaches TIMEOUT_CYC-1 with no handshake, go to OUT with inst=NOP, fault=1, cause=10.
//    - A late rvalid_i is ignored until the next R state.
//  - Simultaneous events: a handshake in the same cycle as timeout expiry wins (normal path).
//  - Reset values (async, immediate):
//    - state=IDLE, so pc_ready_o=1.
//    - arvalid_o=0, rready_o=0, inst_valid_o=0, fault_o=0, fault_cause_o=0.
//    - inst_o=0, inst_pc_o=0, araddr_o=0, counter=0.
//  - Reset mid-fetch abandons the transaction. Memory shares rst, so no outstanding response is
//    expected after release.
//  - Counter width = $clog2(TIMEOUT_CYC)+1; saturates, never wraps.
// CONFIGURATION
//  - YSYX_23060278_IFU_ALIGN_CHK_EN defined:
//    - In IDLE, a pc_i with pc_i[1:0]!=0 is latched and goes directly to OUT.
//    - In that case: inst=NOP, fault=1, cause=11; no bus transaction issued.
//  - Undefined: pc_i[1:0] is ignored for checking, araddr_o=pc_q unchanged, cause 11 is never
//    produced.
// STRUCTURE
//  - Shared package ysyx_23060278_pkg holds:
//    - state encodings (IFU_IDLE/AR/R/OUT, 2 bits)
//    - NOP constant 32'h0000_0013
//    - fault cause codes
//    - RESP_OKAY=2'b00
//  - Sub-module ysyx_23060278_ifu_timer: clear/enable/expire counter, parameter TIMEOUT_CYC.
//  - Everything else lives in the top IFU file.
// TESTING
//  - Zero-wait fetch, pc_i=0x8000_0000, mem returns 0x0050_0093 OKAY, inst_ready_i=1:
//    expect inst_valid_o at cycle 3, inst_o=0x0050_0093, inst_pc_o=0x8000_0000, fault_o=0.
//  - arready_i held low 3 cycles, rvalid_i delayed 2 cycles:
//    araddr_o stable through AR; inst_valid_o at cycle 8; data correct.
//  - rresp_i=2'b10 with rdata_i=0xDEAD_BEEF: expect inst_o=0x0000_0013, fault_o=1,
//    fault_cause_o=01.
//  - arready_i never asserted, TIMEOUT_CYC=16: expect inst_valid_o with fault_cause_o=10;
//    arvalid_o drops on OUT entry.
//  - inst_ready_i low 5 cycles in OUT: outputs held stable, pc_ready_o=0;
//    rst pulse mid-R then clears all outputs asynchronously.
//  - With YSYX_23060278_IFU_ALIGN_CHK_EN, pc_i=0x8000_0002: no arvalid_o ever,
//    fault_cause_o=11 at cycle 1. Without the macro: normal fetch at 0x8000_0002.

Source files
------------

// File: rtl/ysyx_23060278_pkg.sv
// Shared IFU definitions: FSM state encoding, NOP instruction, fault cause codes and AXI response codes.
package ysyx_23060278_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_AR   = 2'd1,
        IFU_R    = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b11;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060278_ifu_timer.sv
// Bus wait counter: clear has priority, counts while enabled, saturates at all-ones and
// flags expiry once TIMEOUT_CYC-1 cycles have elapsed in the current phase.
module ysyx_23060278_ifu_timer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt >= LIMIT);

endmodule

// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: one-in-flight AR/R read of a 32-bit word per accepted PC.
// Define YSYX_23060278_IFU_ALIGN_CHK_EN to fault misaligned PCs without a bus access.
module ysyx_23060278_ifu
    import ysyx_23060278_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [31:0]       rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              fault_o,
    output logic [1:0]        fault_cause_o
);

    ifu_state_e        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic              r_pc_ready;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_inst_valid;
    logic              r_fault;
    logic [1:0]        r_cause;

    logic w_misaligned;
    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_expire;

`ifdef YSYX_23060278_IFU_ALIGN_CHK_EN
    assign w_misaligned = (pc_i[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Counter restarts on entry to each bus phase, so AR and R each get a full budget.
    assign w_tmr_clr = ((r_state == IFU_IDLE) && pc_valid_i && !w_misaligned) ||
                       ((r_state == IFU_AR) && arready_i);
    assign w_tmr_en  = (r_state == IFU_AR) || (r_state == IFU_R);

    ysyx_23060278_ifu_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IFU_IDLE;
            r_pc         <= '0;
            r_inst       <= '0;
            r_pc_ready   <= 1'b1;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_cause      <= CAUSE_NONE;
        end else begin
            case (r_state)
                IFU_IDLE: begin
                    if (pc_valid_i) begin
                        r_pc       <= pc_i;
                        r_pc_ready <= 1'b0;
                        if (w_misaligned) begin
                            r_state      <= IFU_OUT;
                            r_inst       <= NOP;
                            r_fault      <= 1'b1;
                            r_cause      <= CAUSE_MISALIGN;
                            r_inst_valid <= 1'b1;
                        end else begin
                            r_state   <= IFU_AR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                IFU_AR: begin
                    // Handshake is checked first so it wins over a same-cycle expiry.
                    if (arready_i) begin
                        r_state   <= IFU_R;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end else if (w_expire) begin
                        r_state      <= IFU_OUT;
                        r_arvalid    <= 1'b0;
                        r_inst       <= NOP;
                        r_fault      <= 1'b1;
                        r_cause      <= CAUSE_TIMEOUT;
                        r_inst_valid <= 1'b1;
                    end
                end
                IFU_R: begin
                    if (rvalid_i) begin
                        r_state      <= IFU_OUT;
                        r_rready     <= 1'b0;
                        r_inst_valid <= 1'b1;
                        if (rresp_i == RESP_OKAY) begin
                            r_inst  <= rdata_i;
                            r_fault <= 1'b0;
                            r_cause <= CAUSE_NONE;
                        end else begin
                            r_inst  <= NOP;
                            r_fault <= 1'b1;
                            r_cause <= CAUSE_BUS_ERR;
                        end
                    end else if (w_expire) begin
                        r_state      <= IFU_OUT;
                        r_rready     <= 1'b0;
                        r_inst       <= NOP;
                        r_fault      <= 1'b1;
                        r_cause      <= CAUSE_TIMEOUT;
                        r_inst_valid <= 1'b1;
                    end
                end
                IFU_OUT: begin
                    if (inst_ready_i) begin
                        r_state      <= IFU_IDLE;
                        r_inst_valid <= 1'b0;
                        r_fault      <= 1'b0;
                        r_cause      <= CAUSE_NONE;
                        r_pc_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IFU_IDLE;
                end
            endcase
        end
    end

    assign pc_ready_o    = r_pc_ready;
    assign araddr_o      = r_pc;
    assign arvalid_o     = r_arvalid;
    assign rready_o      = r_rready;
    assign inst_o        = r_inst;
    assign inst_pc_o     = r_pc;
    assign inst_valid_o  = r_inst_valid;
    assign fault_o       = r_fault;
    assign fault_cause_o = r_cause;

endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
// Self-checking bench for ysyx_23060278_ifu: directed scenarios plus randomized fetches
// against a latency/outcome model derived from the fetch rules.
module tb_ysyx_23060278_ifu;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TO     = 16;
    localparam logic [31:0] NOP_I  = 32'h0000_0013;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc_i;
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic [ADDR_W-1:0] araddr_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [31:0]       rdata_i;
    logic [1:0]        rresp_i;
    logic              rvalid_i;
    logic              rready_o;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic              fault_o;
    logic [1:0]        fault_cause_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    ysyx_23060278_ifu #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_valid_i    (pc_valid_i),
        .pc_ready_o    (pc_ready_o),
        .araddr_o      (araddr_o),
        .arvalid_o     (arvalid_o),
        .arready_i     (arready_i),
        .rdata_i       (rdata_i),
        .rresp_i       (rresp_i),
        .rvalid_i      (rvalid_i),
        .rready_o      (rready_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outcome of one fetch from the bus timing: each phase lasts delay+1 cycles unless the
    // delay reaches the timeout budget, in which case the phase lasts exactly TO cycles.
    task automatic model_fetch(input logic [31:0] pc, input int unsigned ar_dly,
                               input int unsigned r_dly, input logic [1:0] resp,
                               input logic [31:0] data, output int unsigned exp_cyc,
                               output logic [31:0] exp_inst, output logic exp_fault,
                               output logic [1:0] exp_cause);
        logic align_chk;
`ifdef YSYX_23060278_IFU_ALIGN_CHK_EN
        align_chk = 1'b1;
`else
        align_chk = 1'b0;
`endif
        if (align_chk && (pc % 4 != 0)) begin
            exp_cyc = 1; exp_inst = NOP_I; exp_fault = 1'b1; exp_cause = 2'd3;
        end else if (ar_dly >= TO) begin
            exp_cyc = 1 + TO; exp_inst = NOP_I; exp_fault = 1'b1; exp_cause = 2'd2;
        end else if (r_dly >= TO) begin
            exp_cyc = 1 + (ar_dly + 1) + TO; exp_inst = NOP_I; exp_fault = 1'b1; exp_cause = 2'd2;
        end else begin
            exp_cyc = 1 + (ar_dly + 1) + (r_dly + 1);
            if (resp == 2'b00) begin
                exp_inst = data; exp_fault = 1'b0; exp_cause = 2'd0;
            end else begin
                exp_inst = NOP_I; exp_fault = 1'b1; exp_cause = 2'd1;
            end
        end
    endtask

    task automatic run_fetch(input logic [31:0] pc, input int unsigned ar_dly,
                             input int unsigned r_dly, input logic [1:0] resp,
                             input logic [31:0] data, input int unsigned out_dly);
        int unsigned exp_cyc;
        logic [31:0] exp_inst;
        logic        exp_fault;
        logic [1:0]  exp_cause;
        int unsigned cyc;
        int unsigned ar_wait;
        int unsigned r_wait;
        bit          ar_seen;
        bit          done;
        model_fetch(pc, ar_dly, r_dly, resp, data, exp_cyc, exp_inst, exp_fault, exp_cause);
        @(negedge clk);
        check_eq("pc_ready_idle", 32'(pc_ready_o), 32'd1);
        pc_i = pc;
        pc_valid_i = 1'b1;
        @(posedge clk);
        cyc = 0; ar_wait = 0; r_wait = 0; ar_seen = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            pc_valid_i   = 1'b0;
            pc_i         = $urandom;
            arready_i    = 1'b0;
            rvalid_i     = 1'b0;
            inst_ready_i = 1'b0;
            rdata_i      = $urandom;
            rresp_i      = 2'($urandom);
            if (arvalid_o) begin
                ar_seen = 1;
                check_eq("araddr_stable", araddr_o, pc);
                if (ar_wait == ar_dly) arready_i = 1'b1;
                ar_wait++;
            end
            if (rready_o) begin
                if (r_wait == r_dly) begin
                    rvalid_i = 1'b1;
                    rresp_i  = resp;
                    rdata_i  = data;
                end
                r_wait++;
            end
            if (inst_valid_o) begin
                check_eq("latency", cyc, exp_cyc);
                check_eq("arvalid_off_in_out", 32'(arvalid_o), 32'd0);
                check_eq("rready_off_in_out", 32'(rready_o), 32'd0);
                if (exp_cause == 2'd3) check_eq("no_ar_misaligned", 32'(ar_seen), 32'd0);
                for (int k = 0; k <= int'(out_dly); k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        arready_i = 1'($urandom);
                        rvalid_i  = 1'($urandom);
                    end
                    check_eq("out_valid", 32'(inst_valid_o), 32'd1);
                    check_eq("out_inst", inst_o, exp_inst);
                    check_eq("out_pc", inst_pc_o, pc);
                    check_eq("out_fault", 32'(fault_o), 32'(exp_fault));
                    check_eq("out_cause", 32'(fault_cause_o), 32'(exp_cause));
                    check_eq("pc_ready_busy", 32'(pc_ready_o), 32'd0);
                end
                inst_ready_i = 1'b1;
                @(negedge clk);
                inst_ready_i = 1'b0;
                arready_i    = 1'b0;
                rvalid_i     = 1'b0;
                check_eq("released_valid", 32'(inst_valid_o), 32'd0);
                check_eq("released_pc_ready", 32'(pc_ready_o), 32'd1);
                done = 1;
            end
        end
        if (!done) check_eq("inst_valid_bound", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string phase);
        check_eq({phase, "_pc_ready"}, 32'(pc_ready_o), 32'd1);
        check_eq({phase, "_arvalid"}, 32'(arvalid_o), 32'd0);
        check_eq({phase, "_rready"}, 32'(rready_o), 32'd0);
        check_eq({phase, "_inst_valid"}, 32'(inst_valid_o), 32'd0);
        check_eq({phase, "_fault"}, 32'(fault_o), 32'd0);
        check_eq({phase, "_cause"}, 32'(fault_cause_o), 32'd0);
        check_eq({phase, "_inst"}, inst_o, 32'd0);
        check_eq({phase, "_inst_pc"}, inst_pc_o, 32'd0);
        check_eq({phase, "_araddr"}, araddr_o, 32'd0);
    endtask

    task automatic reset_mid_r();
        @(negedge clk);
        pc_i = 32'h8000_1000;
        pc_valid_i = 1'b1;
        @(negedge clk);
        pc_valid_i = 1'b0;
        arready_i  = 1'b1;
        @(negedge clk);
        arready_i = 1'b0;
        check_eq("mid_r_rready", 32'(rready_o), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("post_rst");
    endtask

    initial begin
        logic [31:0] pc;
        logic [1:0]  resp;
        int unsigned ar_dly;
        int unsigned r_dly;
        rst = 1'b1;
        pc_i = '0; pc_valid_i = 1'b0; arready_i = 1'b0;
        rdata_i = '0; rresp_i = '0; rvalid_i = 1'b0; inst_ready_i = 1'b0;
        #12 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run_fetch(32'h8000_0000, 0, 0, 2'b00, 32'h0050_0093, 0);
        run_fetch(32'h8000_0004, 3, 2, 2'b00, 32'h00A0_0113, 0);
        run_fetch(32'h8000_0008, 0, 0, 2'b10, 32'hDEAD_BEEF, 0);
        run_fetch(32'h8000_000C, 40, 0, 2'b00, 32'h1234_5678, 0);
        run_fetch(32'h8000_0010, 1, 40, 2'b00, 32'h1234_5678, 2);
        run_fetch(32'h8000_0014, TO - 1, TO - 1, 2'b00, 32'hCAFE_F00D, 1);
        run_fetch(32'h8000_0018, 0, 1, 2'b00, 32'h0000_0073, 5);
        reset_mid_r();
        run_fetch(32'h8000_0002, 0, 0, 2'b00, 32'h0010_0093, 0);

        for (int i = 0; i < 120; i++) begin
            pc = $urandom;
            if ($urandom_range(7) != 0) pc[1:0] = 2'b00;
            ar_dly = ($urandom_range(9) == 0) ? $urandom_range(TO + 4, TO - 1) : $urandom_range(4);
            r_dly  = ($urandom_range(9) == 0) ? $urandom_range(TO + 4, TO - 1) : $urandom_range(4);
            resp   = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            run_fetch(pc, ar_dly, r_dly, resp, $urandom, $urandom_range(3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
